mult_sequencer: RTL and testbench
=================================

MULT_SEQUENCER -- requirements
Module: mult_sequencer

Interface
REQ-001 SHALL have parameter WORD_LENGTH, default 8: operand width, which is also the maximum number of CALC iterations.
REQ-002 SHALL have parameter EARLY_EXIT, default 1: when 1, CALC ends as soon as the multiplier register is zero.
REQ-003 clk  input  1  single clock; all state changes on the rising edge.
REQ-004 reset  input  1  reset; synchronous and active-high.
REQ-005 start  input  1  request to begin a multiplication; sampled only in IDLE.
REQ-006 mplr_lsb  input  1  bit 0 of the multiplier shift register (right-shifting).
REQ-007 mplr_zero  input  1  high when the multiplier shift register is all zeros.
REQ-008 load  output  1  parallel-load strobe for the multiplicand (left-shift) and multiplier (right-shift) registers.
REQ-009 shift  output  1  shift strobe for both operand registers.
REQ-010 acc_clear  output  1  clears the product accumulator.
REQ-011 acc_en  output  1  adds the current multiplicand into the accumulator.
REQ-012 ready  output  1  high in IDLE.
REQ-013 done  output  1  one-cycle pulse; product is valid in the accumulator.
REQ-014 iter  output  $clog2(WORD_LENGTH)  current CALC iteration index.

Function
REQ-015 States SHALL be IDLE, LOAD, CALC and DONE, held in a registered state variable.
REQ-016 IDLE transitions: to LOAD when start=1, else remain in IDLE.
REQ-017 LOAD transitions: always to CALC after one cycle.
REQ-018 DONE transitions: always to IDLE after one cycle.
REQ-019 LOAD outputs: load=1 and acc_clear=1 for exactly one cycle; iter is cleared to 0.
REQ-020 CALC with EARLY_EXIT=1 and mplr_zero=1: shift=0 and acc_en=0; next state is DONE.
REQ-021 CALC otherwise: shift=1, acc_en=mplr_lsb (combinational, Mealy); iter increments.
REQ-022 CALC terminates: when a shift is issued with iter==WORD_LENGTH-1, next state is DONE.
REQ-023 load, acc_clear, ready and done SHALL decode from state only (Moore).
REQ-024 shift and acc_en SHALL be 0 outside CALC.
REQ-025 Latency without early exit: start sampled at edge N; LOAD in cycle N+1; CALC in cycles N+2..N+WORD_LENGTH+1; done in cycle N+WORD_LENGTH+2.
REQ-026 start while not in IDLE SHALL be ignored, with no queuing.
REQ-027 start held high continuously: IDLE is spent for exactly one cycle between a DONE and the next LOAD.
REQ-028 load and shift SHALL never be high in the same cycle.
REQ-029 acc_clear and acc_en SHALL never be high in the same cycle.
REQ-030 iter SHALL wrap only through LOAD, never by incrementing past WORD_LENGTH-1.

Reset
REQ-031 reset=1 at a rising edge SHALL force state=IDLE and iter=0, overriding start and any in-progress operation.
REQ-032 Output values during and after reset: ready=1; load, shift, acc_clear, acc_en and done all 0.
REQ-033 Reset mid-CALC SHALL abort the operation with no done pulse; the next start begins a fresh LOAD.

Structure
REQ-034 The state enumeration and its encoding constants SHALL live in the shared package mult_pkg.
REQ-035 The iteration counter SHALL be a sub-module, iter_counter (synchronous clear, enable, WORD_LENGTH-parameterised terminal-count flag).
REQ-036 Operand and accumulator registers SHALL be external to this block and driven by load, shift, acc_clear and acc_en.

Verification
REQ-037 WORD_LENGTH=8, EARLY_EXIT=0, multiplier 0xA5: acc_en pattern across CALC is 1,0,1,0,0,1,0,1; done exactly 10 cycles after start is sampled.
REQ-038 EARLY_EXIT=1, multiplier 0x03: three CALC cycles (acc_en 1,1,0), with shift=0 on the third; done 5 cycles after start.
REQ-039 EARLY_EXIT=1, multiplier 0x00: CALC lasts one cycle with no shift and no acc_en; done 3 cycles after start.
REQ-040 start pulsed during CALC: no effect on state or iter, and exactly one done pulse results.
REQ-041 reset asserted at iter=4: next cycle is IDLE, ready=1, no done pulse, all strobes 0.
REQ-042 start held high for two operations: done, then IDLE (1 cycle), then LOAD, then a second done 10 cycles later; load never coincides with shift.

Source files
------------

// File: rtl/mult_pkg.sv
// Shared definitions for the shift-and-add multiplier sequencer.
package mult_pkg;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_LOAD = 2'd1;
  localparam logic [1:0] ST_CALC = 2'd2;
  localparam logic [1:0] ST_DONE = 2'd3;

  typedef enum logic [1:0] {
    IDLE = ST_IDLE,
    LOAD = ST_LOAD,
    CALC = ST_CALC,
    DONE = ST_DONE
  } state_t;

endpackage

// File: rtl/iter_counter.sv
// CALC iteration counter: synchronous clear, count enable, terminal-count flag.
module iter_counter #(
  parameter int unsigned WORD_LENGTH = 8
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic                           clear,
  input  logic                           en,
  output logic [$clog2(WORD_LENGTH)-1:0] count,
  output logic                           tc
);

  localparam int unsigned W = $clog2(WORD_LENGTH);
  localparam logic [W-1:0] LAST = W'(WORD_LENGTH - 1);

  assign tc = (count == LAST);

  // Count holds at the last index; only a clear brings it back to zero.
  always_ff @(posedge clk) begin
    if (reset || clear) begin
      count <= '0;
    end else if (en && !tc) begin
      count <= count + W'(1);
    end
  end

endmodule

// File: rtl/mult_sequencer.sv
// Control sequencer for an external shift-and-add multiplier datapath.
module mult_sequencer
  import mult_pkg::*;
#(
  parameter int WORD_LENGTH = 8,
  parameter int EARLY_EXIT  = 1
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic                           start,
  input  logic                           mplr_lsb,
  input  logic                           mplr_zero,
  output logic                           load,
  output logic                           shift,
  output logic                           acc_clear,
  output logic                           acc_en,
  output logic                           ready,
  output logic                           done,
  output logic [$clog2(WORD_LENGTH)-1:0] iter
);

  state_t state;
  logic   exit_now;
  logic   last_iter;

  assign exit_now = (EARLY_EXIT != 0) && mplr_zero;

  // Moore strobes decoded straight from the registered state.
  assign load      = (state == LOAD);
  assign acc_clear = (state == LOAD);
  assign ready     = (state == IDLE);
  assign done      = (state == DONE);

  // Mealy datapath strobes: shift and conditional add while in CALC.
  always_comb begin
    shift  = 1'b0;
    acc_en = 1'b0;
    if (state == CALC && !exit_now) begin
      shift  = 1'b1;
      acc_en = mplr_lsb;
    end
  end

  // State register and transition logic.
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      case (state)
        IDLE:    if (start) state <= LOAD;
        LOAD:    state <= CALC;
        CALC:    if (exit_now || last_iter) state <= DONE;
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  iter_counter #(
    .WORD_LENGTH(WORD_LENGTH)
  ) u_iter (
    .clk  (clk),
    .reset(reset),
    .clear(load),
    .en   (shift),
    .count(iter),
    .tc   (last_iter)
  );

endmodule

// File: tb/tb_mult_sequencer.sv
// Bench for mult_sequencer: models the external operand/accumulator registers
// and checks strobe timing plus the resulting product.
module tb_mult_sequencer;

  logic        clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset     [2];
  logic        start     [2];
  logic        mplr_lsb  [2];
  logic        mplr_zero [2];
  logic        load      [2];
  logic        shift     [2];
  logic        acc_clear [2];
  logic        acc_en    [2];
  logic        ready     [2];
  logic        done      [2];
  logic [2:0]  iter      [2];

  logic [7:0]  opa   [2];
  logic [7:0]  opb   [2];
  logic [15:0] mcand [2];
  logic [7:0]  mplr  [2];
  logic [15:0] acc   [2];

  logic [15:0] exp_q0 [$];
  logic [15:0] exp_q1 [$];

  int checks   = 0;
  int failures = 0;

  mult_sequencer #(.WORD_LENGTH(8), .EARLY_EXIT(0)) dut_full (
    .clk(clk), .reset(reset[0]), .start(start[0]),
    .mplr_lsb(mplr_lsb[0]), .mplr_zero(mplr_zero[0]),
    .load(load[0]), .shift(shift[0]), .acc_clear(acc_clear[0]), .acc_en(acc_en[0]),
    .ready(ready[0]), .done(done[0]), .iter(iter[0])
  );

  mult_sequencer #(.WORD_LENGTH(8), .EARLY_EXIT(1)) dut_early (
    .clk(clk), .reset(reset[1]), .start(start[1]),
    .mplr_lsb(mplr_lsb[1]), .mplr_zero(mplr_zero[1]),
    .load(load[1]), .shift(shift[1]), .acc_clear(acc_clear[1]), .acc_en(acc_en[1]),
    .ready(ready[1]), .done(done[1]), .iter(iter[1])
  );

  // External datapath: multiplicand shifts left, multiplier shifts right.
  always @(posedge clk) begin
    for (int i = 0; i < 2; i++) begin
      if (reset[i]) begin
        mcand[i] <= '0;
        mplr[i]  <= '0;
        acc[i]   <= '0;
      end else begin
        if (load[i]) begin
          mcand[i] <= {8'h00, opa[i]};
          mplr[i]  <= opb[i];
        end else if (shift[i]) begin
          mcand[i] <= mcand[i] << 1;
          mplr[i]  <= mplr[i] >> 1;
        end
        if (acc_clear[i])   acc[i] <= '0;
        else if (acc_en[i]) acc[i] <= acc[i] + mcand[i];
      end
    end
  end

  always_comb begin
    for (int i = 0; i < 2; i++) begin
      mplr_lsb[i]  = mplr[i][0];
      mplr_zero[i] = (mplr[i] == 8'h00);
    end
  end

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Scoreboard side and cycle-wide invariants.
  always @(negedge clk) begin
    for (int i = 0; i < 2; i++) begin
      if (load[i] || shift[i])
        check("load_shift_excl", 16'(load[i] & shift[i]), 16'h0);
      if (acc_clear[i] || acc_en[i])
        check("clear_en_excl", 16'(acc_clear[i] & acc_en[i]), 16'h0);
      if (done[i]) begin
        if (i == 0) begin
          if (exp_q0.size() == 0) check("spurious_done0", 16'(done[i]), 16'h0);
          else check("product0", acc[i], exp_q0.pop_front());
        end else begin
          if (exp_q1.size() == 0) check("spurious_done1", 16'(done[i]), 16'h0);
          else check("product1", acc[i], exp_q1.pop_front());
        end
      end
    end
  end

  task automatic push_exp(input int k, input logic [7:0] a, input logic [7:0] b);
    logic [15:0] p;
    p = {8'h00, a} * {8'h00, b};
    if (k == 0) exp_q0.push_back(p);
    else        exp_q1.push_back(p);
  endtask

  // One operation from IDLE: start sampled at edge N, then lat cycles to done.
  task automatic run_op(input int k, input logic [7:0] a, input logic [7:0] b,
                        input int lat, input int ncalc,
                        input logic [7:0] en_pat, input logic [7:0] sh_pat,
                        input int poke, input string tag);
    int j;
    opa[k] = a;
    opb[k] = b;
    push_exp(k, a, b);
    start[k] = 1'b1;
    @(posedge clk);
    #1 start[k] = 1'b0;
    for (int c = 1; c <= lat; c++) begin
      @(negedge clk);
      if (c == 1) begin
        check({tag, ":load"},      16'(load[k]),      16'h1);
        check({tag, ":acc_clear"}, 16'(acc_clear[k]), 16'h1);
        check({tag, ":ready_busy"}, 16'(ready[k]),    16'h0);
      end
      if (c >= 2 && c <= ncalc + 1) begin
        j = c - 2;
        check({tag, ":acc_en"}, 16'(acc_en[k]), 16'(en_pat[j]));
        check({tag, ":shift"},  16'(shift[k]),  16'(sh_pat[j]));
        check({tag, ":iter"},   16'(iter[k]),   16'(j));
      end
      check({tag, ":done"}, 16'(done[k]), 16'(c == lat));
      if (poke != 0 && c == poke)     start[k] = 1'b1;
      if (poke != 0 && c == poke + 1) start[k] = 1'b0;
    end
    @(negedge clk);
    check({tag, ":ready_after"}, 16'(ready[k]), 16'h1);
    check({tag, ":done_after"},  16'(done[k]),  16'h0);
  endtask

  initial begin
    logic found;
    logic saw_done;

    for (int i = 0; i < 2; i++) begin
      reset[i] = 1'b1;
      start[i] = 1'b0;
      opa[i]   = '0;
      opb[i]   = '0;
    end
    repeat (2) @(posedge clk);
    #1;
    reset[0] = 1'b0;
    reset[1] = 1'b0;
    @(negedge clk);
    for (int i = 0; i < 2; i++) begin
      check("rst:ready",     16'(ready[i]),     16'h1);
      check("rst:load",      16'(load[i]),      16'h0);
      check("rst:shift",     16'(shift[i]),     16'h0);
      check("rst:acc_clear", 16'(acc_clear[i]), 16'h0);
      check("rst:acc_en",    16'(acc_en[i]),    16'h0);
      check("rst:done",      16'(done[i]),      16'h0);
      check("rst:iter",      16'(iter[i]),      16'h0);
    end

    run_op(0, 8'h37, 8'hA5, 10, 8, 8'hA5, 8'hFF, 0, "full_a5");
    run_op(0, 8'hC3, 8'h00, 10, 8, 8'h00, 8'hFF, 0, "full_00");
    run_op(1, 8'h5B, 8'h03,  5, 3, 8'h03, 8'h03, 0, "early_03");
    run_op(1, 8'h5B, 8'h00,  3, 1, 8'h00, 8'h00, 0, "early_00");
    run_op(1, 8'hFF, 8'h80, 10, 8, 8'h80, 8'hFF, 0, "early_80");
    run_op(0, 8'hFF, 8'hFF, 10, 8, 8'hFF, 8'hFF, 4, "poke");

    // Abort mid-CALC with reset at iter 4: no product is expected.
    opa[0] = 8'h99;
    opb[0] = 8'hFF;
    start[0] = 1'b1;
    @(posedge clk);
    #1 start[0] = 1'b0;
    found = 1'b0;
    for (int n = 0; n < 20 && !found; n++) begin
      @(negedge clk);
      if (iter[0] == 3'd4 && shift[0]) found = 1'b1;
    end
    check("abort:reach_iter4", 16'(found), 16'h1);
    reset[0] = 1'b1;
    @(posedge clk);
    #1 reset[0] = 1'b0;
    @(negedge clk);
    check("abort:ready",     16'(ready[0]),     16'h1);
    check("abort:load",      16'(load[0]),      16'h0);
    check("abort:shift",     16'(shift[0]),     16'h0);
    check("abort:acc_clear", 16'(acc_clear[0]), 16'h0);
    check("abort:acc_en",    16'(acc_en[0]),    16'h0);
    check("abort:done",      16'(done[0]),      16'h0);
    check("abort:iter",      16'(iter[0]),      16'h0);
    saw_done = 1'b0;
    repeat (12) begin
      @(negedge clk);
      saw_done = saw_done | done[0];
    end
    check("abort:no_done", 16'(saw_done), 16'h0);
    run_op(0, 8'h12, 8'h34, 10, 8, 8'h34, 8'hFF, 0, "after_abort");

    // start held high across two back-to-back operations.
    opa[0] = 8'h0F;
    opb[0] = 8'h11;
    push_exp(0, 8'h0F, 8'h11);
    push_exp(0, 8'h0F, 8'h11);
    start[0] = 1'b1;
    @(posedge clk);
    #1;
    for (int c = 1; c <= 21; c++) begin
      @(negedge clk);
      check("held:done", 16'(done[0]), 16'(c == 10 || c == 21));
      if (c == 1)  check("held:load1", 16'(load[0]), 16'h1);
      if (c == 11) check("held:idle",  16'(ready[0]), 16'h1);
      if (c == 12) begin
        check("held:load2", 16'(load[0]), 16'h1);
        start[0] = 1'b0;
      end
    end
    @(negedge clk);
    check("held:ready_after", 16'(ready[0]), 16'h1);

    check("queue0_drained", 16'(exp_q0.size()), 16'h0);
    check("queue1_drained", 16'(exp_q1.size()), 16'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
